// File: rtl/piso_tx_if.sv
// piso_tx_if: load handshake and serial-output bundle for the piso_tx transmitter.
// The source (master) presents words on load_valid/load_data and watches
// load_ready; the transmitter (slave) drives the serial outputs.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output dout,
    output dout_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first.
// A word is accepted on an edge with load_valid && load_ready; bit 0 appears on
// dout in the next cycle and one bit follows per clock. Holding load_valid high
// with the next word lets it reload on the last-bit cycle with no idle gap.
// Optional feature macro: PISO_PARITY_EN -- appends an even-parity bit
// (^load_data) after bit WIDTH-1, making each frame WIDTH+1 cycles long.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  piso_tx_if.slave   bus
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  // Even parity over the data word: the appended bit makes the frame's 1-count even.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Full frame as it goes on the wire, bit 0 first.
  function automatic logic [FRAME-1:0] build_frame(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
    return {even_parity(d), d};
`else
    return d;
`endif
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [FRAME-1:0]   shreg_r;       // bits still to send after the one on dout
  logic [FRAME-1:0]   shreg_nxt_s;
  logic [CNT_W-1:0]   cnt_r;         // index of the bit currently on dout
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               dout_r;
  logic               dout_nxt_s;
  logic               dout_valid_r;
  logic               dout_valid_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic [FRAME-1:0]   frame_s;
  logic               last_bit_s;
  logic               load_ready_s;
  logic               accept_s;

  assign frame_s = build_frame(bus.load_data);

  // Handshake decode: ready when idle or while the final frame bit is on dout.
  always_comb begin
    last_bit_s   = 1'b0;
    load_ready_s = 1'b0;
    accept_s     = 1'b0;
    if (state_r == SHIFT) begin
      last_bit_s = (cnt_r == LAST_CNT);
    end else begin
      last_bit_s = 1'b0;
    end
    load_ready_s = (state_r == IDLE) || last_bit_s;
    accept_s     = bus.load_valid && load_ready_s;
  end

  // Next-state and datapath decode; an accepted word always restarts the frame at bit 0.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    dout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SHIFT;
          dout_nxt_s  = frame_s[0];
          shreg_nxt_s = {1'b0, frame_s[FRAME-1:1]};
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE;
          shreg_nxt_s = '0;
          cnt_nxt_s   = CNT_ZERO;
          dout_nxt_s  = 1'b0;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          if (accept_s) begin
            // Back-to-back reload: next word's bit 0 follows immediately.
            state_nxt_s = SHIFT;
            dout_nxt_s  = frame_s[0];
            shreg_nxt_s = {1'b0, frame_s[FRAME-1:1]};
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = IDLE;
            shreg_nxt_s = '0;
            cnt_nxt_s   = CNT_ZERO;
            dout_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = SHIFT;
          dout_nxt_s  = shreg_r[0];
          shreg_nxt_s = {1'b0, shreg_r[FRAME-1:1]};
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        shreg_nxt_s = '0;
        cnt_nxt_s   = CNT_ZERO;
        dout_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered status flags follow the state being entered, so they line up with dout.
  always_comb begin
    dout_valid_nxt_s = 1'b0;
    busy_nxt_s       = 1'b0;
    done_nxt_s       = 1'b0;
    if (state_nxt_s == SHIFT) begin
      dout_valid_nxt_s = 1'b1;
      busy_nxt_s       = 1'b1;
      done_nxt_s       = (cnt_nxt_s == LAST_CNT);
    end else begin
      dout_valid_nxt_s = 1'b0;
      busy_nxt_s       = 1'b0;
      done_nxt_s       = 1'b0;
    end
  end

  // FSM state register; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_r      <= '0;
      cnt_r        <= CNT_ZERO;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      shreg_r      <= shreg_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed, table-driven bench for piso_tx (WIDTH=4), with a small
// SIPO receiver model on dout for the loopback check. Honours PISO_PARITY_EN.
module tb_piso_tx;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef struct {
    logic [3:0] data;
    logic [4:0] frame_exp;  // hand-computed wire bits, bit 0 first; bit 4 is parity
  } vec_t;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;
  logic [3:0] sipo_q;
  vec_t vecs [6];

  piso_tx_if #(.WIDTH(WIDTH)) bus ();

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: LSB-first SIPO fed by dout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sipo_q <= 4'h0;
    end else if (bus.dout_valid) begin
      sipo_q <= {bus.dout, sipo_q[3:1]};
    end else begin
      sipo_q <= sipo_q;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"},       {31'd0, bus.dout},       32'd0);
    chk({tag, "_dout_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    chk({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
    chk({tag, "_done"},       {31'd0, bus.done},       32'd0);
  endtask

  // Send one word from idle and check every frame cycle plus the return to idle.
  task automatic run_word(input logic [3:0] data, input logic [4:0] fexp);
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.load_ready}, 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    @(negedge clk);                       // cycle T+1
    bus.load_valid = 1'b0;
    bus.load_data  = ~data;               // must not affect the frame in flight
    for (int i = 0; i < FRAME; i++) begin
      chk("bit_dout",  {31'd0, bus.dout},       {31'd0, fexp[i]});
      chk("bit_valid", {31'd0, bus.dout_valid}, 32'd1);
      chk("bit_busy",  {31'd0, bus.busy},       32'd1);
      chk("bit_done",  {31'd0, bus.done},       {31'd0, (i == FRAME - 1)});
      chk("bit_ready", {31'd0, bus.load_ready}, {31'd0, (i == FRAME - 1)});
`ifdef PISO_PARITY_EN
      if (i == WIDTH) chk("loopback_q", {28'd0, sipo_q}, {28'd0, data});
`endif
      if (i < FRAME - 1) @(negedge clk);
    end
    @(negedge clk);                       // cycle T+FRAME+1
    chk_idle("post_frame");
`ifndef PISO_PARITY_EN
    chk("loopback_q", {28'd0, sipo_q}, {28'd0, data});
`endif
  endtask

  logic [9:0] b2b_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{data: 4'b1011, frame_exp: 5'b1_1011};
    vecs[1] = '{data: 4'hA,    frame_exp: 5'b0_1010};
    vecs[2] = '{data: 4'b0111, frame_exp: 5'b1_0111};
    vecs[3] = '{data: 4'h0,    frame_exp: 5'b0_0000};
    vecs[4] = '{data: 4'hF,    frame_exp: 5'b0_1111};
    vecs[5] = '{data: 4'b0110, frame_exp: 5'b0_0110};
`ifdef PISO_PARITY_EN
    b2b_exp = {1'b0, 4'hC, 1'b0, 4'h3};
`else
    b2b_exp = {2'b00, 4'hC, 4'h3};
`endif

    // Reset held with a pending load: nothing may come out.
    rstn           = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("reset");
    end
    bus.load_valid = 1'b0;
    rstn           = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.load_ready}, 32'd1);
    chk_idle("after_reset");

    // Table of single words.
    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].data, vecs[v].frame_exp);
    end

    // Back-to-back 4'h3 then 4'hC with load_valid held high.
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 4'h3;
    @(negedge clk);
    bus.load_data  = 4'hC;                // offered while not ready; taken on last bit
    for (int i = 0; i < 2 * FRAME; i++) begin
      chk("b2b_dout",  {31'd0, bus.dout},       {31'd0, b2b_exp[i]});
      chk("b2b_valid", {31'd0, bus.dout_valid}, 32'd1);
      chk("b2b_done",  {31'd0, bus.done},
          {31'd0, (i == FRAME - 1) || (i == 2 * FRAME - 1)});
      if (i == FRAME) bus.load_valid = 1'b0;
      if (i < 2 * FRAME - 1) @(negedge clk);
    end
    @(negedge clk);
    chk_idle("b2b_end");

    // Mid-frame reset: 4'hF, reset while bit 1 is on dout.
    bus.load_valid = 1'b1;
    bus.load_data  = 4'hF;
    @(negedge clk);
    bus.load_valid = 1'b0;
    @(negedge clk);
    chk("mid_bit1", {31'd0, bus.dout}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk_idle("mid_reset_async");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      chk_idle("mid_after_release");
    end

    // Recovery: a fresh word goes out normally.
    run_word(4'h3, 5'b0_0011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
